// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 inverse key schedule: FSM states,
// word type, round constants and the forward S-box.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, EXPAND, SERVE} state_t;
  typedef logic [31:0] word_t;

  localparam int NR = 10;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Indices outside 1..10 never reach the datapath output; return 0 for them.
  function automatic logic [7:0] rcon_of(input logic [3:0] i);
    if (i >= 4'd1 && i <= 4'd10) return RCON[i];
    return 8'h00;
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box lookups on one 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout = {SBOX[din[31:24]], SBOX[din[23:16]], SBOX[din[15:8]], SBOX[din[7:0]]};

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 round-key generator emitting keys 10..0 for decryption.
// Optional macro AES_INV_KS_REPLAY_EN adds a round-10 cache and replay_valid input.
//
// state  | meaning
// IDLE   | key_ready=1, waiting for a cipher key (or a replay request)
// EXPAND | forward expansion, one round per cycle, cnt = round being built
// SERVE  | rk_out/rk_round valid; each accept steps one round backwards
module aes_inv_key_sched
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [KW-1:0] key_in,
  input  logic          key_valid,
  output logic          key_ready,
  output logic [KW-1:0] rk_out,
  output logic [3:0]    rk_round,
  output logic          rk_valid,
  input  logic          rk_ready
`ifdef AES_INV_KS_REPLAY_EN
  ,input logic          replay_valid
`endif
);

  state_t        state;
  logic [KW-1:0] wk;
  logic [3:0]    cnt;
  logic [31:0]   sub_in, sub_out, t_word, p3;
  logic [31:0]   f0, f1, f2, f3;
  logic [7:0]    rc;
  logic [KW-1:0] fwd, rev;

`ifdef AES_INV_KS_REPLAY_EN
  logic [KW-1:0] cache;
  logic          cache_vld;
`endif

  assign key_ready = (state == IDLE);

  // One S-box bank shared by both directions; state picks the word fed to it.
  always_comb begin
    p3     = rk_out[31:0] ^ rk_out[63:32];
    sub_in = (state == EXPAND) ? rot_word(wk[31:0]) : rot_word(p3);
    rc     = (state == EXPAND) ? rcon_of(cnt) : rcon_of(rk_round);
    t_word = sub_out ^ {rc, 24'h0};
    f0     = wk[127:96] ^ t_word;
    f1     = wk[95:64] ^ f0;
    f2     = wk[63:32] ^ f1;
    f3     = wk[31:0] ^ f2;
    fwd    = {f0, f1, f2, f3};
    rev    = {rk_out[127:96] ^ t_word,
              rk_out[127:96] ^ rk_out[95:64],
              rk_out[95:64] ^ rk_out[63:32],
              p3};
  end

  aes_sub_word u_sub_word (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wk       <= '0;
      cnt      <= '0;
      rk_out   <= '0;
      rk_round <= '0;
      rk_valid <= 1'b0;
`ifdef AES_INV_KS_REPLAY_EN
      cache     <= '0;
      cache_vld <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            wk    <= key_in;
            cnt   <= 4'd1;
            state <= EXPAND;
          end
`ifdef AES_INV_KS_REPLAY_EN
          else if (replay_valid && cache_vld) begin
            wk       <= cache;
            rk_out   <= cache;
            rk_round <= 4'(NR);
            rk_valid <= 1'b1;
            state    <= SERVE;
          end
`endif
        end
        EXPAND: begin
          wk <= fwd;
          if (cnt == 4'(NR)) begin
            rk_out   <= fwd;
            rk_round <= 4'(NR);
            rk_valid <= 1'b1;
            state    <= SERVE;
`ifdef AES_INV_KS_REPLAY_EN
            cache     <= fwd;
            cache_vld <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SERVE: begin
          if (rk_ready) begin
            if (rk_round == 4'd0) begin
              rk_valid <= 1'b0;
              state    <= IDLE;
            end else begin
              rk_out   <= rev;
              wk       <= rev;
              rk_round <= rk_round - 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched: table-driven key sequences with a
// scoreboard of expected round keys, plus reset/ignore/replay corner cases.
module tb_aes_inv_key_sched;

  localparam logic [127:0] STD_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
`ifdef AES_INV_KS_REPLAY_EN
  logic         replay_valid;
`endif

  always #5 clk = ~clk;

  aes_inv_key_sched dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .rk_out    (rk_out),
    .rk_round  (rk_round),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready)
`ifdef AES_INV_KS_REPLAY_EN
    ,.replay_valid (replay_valid)
`endif
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int           round;
    logic [127:0] key;
    bit           chk_key;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [127:0] key;
    int           stall_round;
    int           stall_len;
  } case_t;
  case_t cases [3];

  logic [127:0] std_rk [0:10];

  task automatic check_k(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [127:0] k);
    for (int r = 10; r >= 0; r--) begin
      sb_t e;
      e.round   = r;
      e.key     = '0;
      e.chk_key = 1'b1;
      if (k == STD_KEY) e.key = std_rk[r];
      else if (k == ZERO_KEY) begin
        case (r)
          10:      e.key = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
          1:       e.key = 128'h62636363626363636263636362636363;
          0:       e.key = ZERO_KEY;
          default: e.chk_key = 1'b0;
        endcase
      end else e.chk_key = 1'b0;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (!rk_valid && n < 40) begin
      tick;
      n++;
    end
    ok = rk_valid;
    check_i("rk_valid_timeout", int'(rk_valid), 1);
  endtask

  task automatic consume(input int n, input int stall_round, input int stall_len);
    for (int i = 0; i < n; i++) begin
      bit  ok;
      sb_t e;
      wait_valid(ok);
      if (!ok) return;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: got round %0d expected no output", rk_round);
        return;
      end
      e = sbq.pop_front();
      check_i("rk_round", int'(rk_round), e.round);
      if (e.chk_key) check_k("rk_out", rk_out, e.key);
      if (int'(rk_round) == stall_round) begin
        rk_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick;
          check_i("stall_valid", int'(rk_valid), 1);
          check_i("stall_round", int'(rk_round), e.round);
          if (e.chk_key) check_k("stall_out", rk_out, e.key);
        end
        rk_ready = 1'b1;
      end
      tick;
    end
  endtask

  task automatic check_idle(input logic [127:0] last);
    check_i("idle_key_ready", int'(key_ready), 1);
    check_i("idle_rk_valid", int'(rk_valid), 0);
    check_k("idle_rk_out_held", rk_out, last);
    check_i("scoreboard_drained", sbq.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    std_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    std_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    std_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    std_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    std_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    std_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    std_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    std_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    std_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    std_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    std_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    cases[0] = '{key: STD_KEY,  stall_round: -1, stall_len: 0};
    cases[1] = '{key: STD_KEY,  stall_round: 7,  stall_len: 5};
    cases[2] = '{key: ZERO_KEY, stall_round: 0,  stall_len: 3};

    rst       = 1'b1;
    key_in    = '0;
    key_valid = 1'b0;
    rk_ready  = 1'b1;
`ifdef AES_INV_KS_REPLAY_EN
    replay_valid = 1'b0;
`endif
    #12;
    check_i("rst_key_ready", int'(key_ready), 1);
    check_i("rst_rk_valid", int'(rk_valid), 0);
    check_k("rst_rk_out", rk_out, '0);
    check_i("rst_rk_round", int'(rk_round), 0);
    @(negedge clk);
    rst = 1'b0;
    tick;

`ifdef AES_INV_KS_REPLAY_EN
    replay_valid = 1'b1;
    tick;
    tick;
    replay_valid = 1'b0;
    check_i("replay_empty_valid", int'(rk_valid), 0);
    check_i("replay_empty_ready", int'(key_ready), 1);
`endif

    for (int c = 0; c < 3; c++) begin
      key_in    = cases[c].key;
      key_valid = 1'b1;
      push_seq(cases[c].key);
      check_i("accept_key_ready", int'(key_ready), 1);
      tick;
      key_valid = 1'b0;
      key_in    = {$urandom, $urandom, $urandom, $urandom};
      n = 1;
      while (!rk_valid && n < 40) begin
        tick;
        n++;
      end
      check_i("first_latency", n, 11);
      consume(11, cases[c].stall_round, cases[c].stall_len);
      check_idle(cases[c].key);
    end

    // key_valid while busy must be ignored in both EXPAND and SERVE
    key_in    = STD_KEY;
    key_valid = 1'b1;
    push_seq(STD_KEY);
    tick;
    key_in = 128'hffeeddccbbaa99887766554433221100;
    check_i("busy_expand_ready", int'(key_ready), 0);
    tick;
    tick;
    key_valid = 1'b0;
    begin
      bit ok;
      wait_valid(ok);
    end
    rk_ready  = 1'b0;
    key_valid = 1'b1;
    check_i("busy_serve_ready", int'(key_ready), 0);
    tick;
    tick;
    key_valid = 1'b0;
    rk_ready  = 1'b1;
    consume(11, -1, 0);
    check_idle(STD_KEY);

`ifdef AES_INV_KS_REPLAY_EN
    replay_valid = 1'b1;
    push_seq(STD_KEY);
    tick;
    replay_valid = 1'b0;
    check_i("replay_latency_valid", int'(rk_valid), 1);
    consume(11, -1, 0);
    check_idle(STD_KEY);

    key_in       = ZERO_KEY;
    key_valid    = 1'b1;
    replay_valid = 1'b1;
    push_seq(ZERO_KEY);
    tick;
    key_valid    = 1'b0;
    replay_valid = 1'b0;
    check_i("prio_key_ready", int'(key_ready), 0);
    check_i("prio_rk_valid", int'(rk_valid), 0);
    consume(11, -1, 0);
    check_idle(ZERO_KEY);
`endif

    // Reset in the middle of delivery, then a fresh all-zero key
    key_in    = STD_KEY;
    key_valid = 1'b1;
    push_seq(STD_KEY);
    tick;
    key_valid = 1'b0;
    consume(6, -1, 0);
    check_i("pre_reset_round", int'(rk_round), 4);
    #1;
    rst = 1'b1;
    #1;
    check_i("midrst_rk_valid", int'(rk_valid), 0);
    check_k("midrst_rk_out", rk_out, '0);
    check_i("midrst_rk_round", int'(rk_round), 0);
    check_i("midrst_key_ready", int'(key_ready), 1);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    tick;
    key_in    = ZERO_KEY;
    key_valid = 1'b1;
    push_seq(ZERO_KEY);
    tick;
    key_valid = 1'b0;
    consume(11, -1, 0);
    check_idle(ZERO_KEY);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sched.md
Name: aes_inv_key_sched

Overview:
- Iterative AES-128 round-key generator for the decryption datapath.
- Accepts a cipher key and expands forward internally to round key 10.
- Emits round keys in reverse order (10 down to 0) over a valid/ready handshake to the inverse-cipher round XOR stage.
- Each key is recomputed from the previous one by reverse expansion, so no 11-entry key RAM is needed.

Parameters:
- NR, 10, number of rounds (AES-128 only; other values are unsupported)
- KW, 128, key and round-key width in bits

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- key_in  input  128  cipher key, FIPS-197 byte order (byte 0 = bits [127:120])
- key_valid  input  1  key_in is valid
- key_ready  output  1  block can accept a key (high only in IDLE)
- rk_out  output  128  current round key
- rk_round  output  4  round index of rk_out (10..0)
- rk_valid  output  1  rk_out/rk_round are valid
- rk_ready  input  1  consumer accepts rk_out

Behaviour:
- Reset values: state=IDLE, rk_out=0, rk_round=0, rk_valid=0, working key register=0, round counter=0. key_ready is decoded from state, so it is 1 while in IDLE, including during reset.
- States:
  - IDLE: key_ready=1. key_valid&&key_ready loads key_in into the working register, sets cnt=1, and moves to EXPAND.
  - EXPAND: one forward step per cycle, using Rcon[cnt]. When cnt==10 completes, move to SERVE with rk_out=round key 10, rk_round=10, rk_valid=1. Total latency is 11 cycles from key acceptance to the first rk_valid.
  - SERVE: rk_valid=1; rk_out and rk_round stay stable while rk_ready=0.
    - On accept with rk_round>0: next cycle holds the reverse step using Rcon[rk_round], and rk_round decrements.
    - On accept with rk_round==0: go to IDLE; rk_valid=0 next cycle; rk_out keeps its last value.
- Words: w0=[127:96] .. w3=[31:0]. T(x)=SubWord(RotWord(x)) ^ {Rcon,24'h0}, with Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- Forward step: w0'=w0^T(w3); w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
- Reverse step from round i: p3=w3^w2; p2=w2^w1; p1=w1^w0; p0=w0^T(p3) using Rcon[i].
- key_valid outside IDLE is ignored; key_in is not sampled.
- rst mid-EXPAND or mid-SERVE: immediate return to the reset values. A partially delivered sequence is abandoned and is not resumed.
- No back-pressure limit: rk_ready may stay low indefinitely.

Optional Feature:
- Macro: AES_INV_KS_REPLAY_EN.
- When defined:
  - Add a 128-bit cache register plus a cache_vld flag, and an input port replay_valid (1 bit).
  - On leaving EXPAND, store round key 10 in the cache and set cache_vld=1.
  - In IDLE with key_valid=0, replay_valid=1 and cache_vld=1: go directly to SERVE next cycle with the cached round-10 key (latency 1).
  - key_valid has priority over replay_valid.
  - replay_valid with cache_vld=0 is ignored.
  - rst clears cache_vld.
- When undefined: no replay_valid port and no cache; every sequence requires EXPAND.

Decomposition:
- Package aes_pkg holds:
  - state_t enum {IDLE, EXPAND, SERVE}
  - NR constant
  - RCON[1:10] byte array
  - 256-entry SBOX constant
  - word_t typedef (logic [31:0])
- Sub-module aes_sub_word: purely combinational; four parallel S-box lookups on a 32-bit word. It is instantiated once and shared by the forward and reverse paths, with a mux on the input word selected by state.

Test Plan:
- Key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 → rk_valid rises 11 cycles after acceptance. Sequence:
  - round 10: d014f9a8c9ee2589e13f0cc8b6630ca6
  - round 1: a0fafe1788542cb123a339392a6c7605
  - round 0: 2b7e151628aed2a6abf7158809cf4f3c
  - key_ready is back to 1 one cycle after round 0 is accepted.
- Back-pressure: hold rk_ready=0 for 5 cycles at rk_round=7 → rk_out and rk_round stay constant; sequence resumes unchanged, with no skipped or duplicated rounds.
- key_valid pulsed during EXPAND and SERVE → ignored; key_ready=0; output sequence is that of the original key.
- Assert rst at rk_round=4 → rk_valid=0, rk_out=0, key_ready=1. A new key (all-zero key) yields round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- With AES_INV_KS_REPLAY_EN: after the first full sequence, pulse replay_valid → rk_valid with round 10 d014f9a8... one cycle later.
- With AES_INV_KS_REPLAY_EN: replay_valid after reset (cache empty) → no response.
- With AES_INV_KS_REPLAY_EN: key_valid and replay_valid together → new key accepted and EXPAND entered.
